// File: rtl/data_mem_be.sv
// data_mem_be: byte-enabled data memory for the MIPS MEM stage.
// Byte/half/word loads and stores, little-endian lanes, registered read data
// (1-cycle latency), misalign/range error pulses, post-reset clear sweep and
// two byte-wide display taps.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   rd, wr              load / store request (sampled at posedge)
//   size                00 byte, 01 half, 1x word
//   sign_ext            loads: 1 sign-extends byte/half, 0 zero-extends
//   addr, wdata         byte address, right-justified store data
//   rdata, rvalid       registered load result and its one-cycle valid pulse
//   busy                reset or clear sweep in progress; requests ignored
//   err_align           one-cycle pulse, misaligned access
//   err_range           one-cycle pulse, addr beyond the array
//   num1, num2          low byte of words TAP1_WORD / TAP2_WORD
module data_mem_be #(
  parameter int unsigned RAM_WORDS = 256,
  parameter int unsigned TAP1_WORD = 10,
  parameter int unsigned TAP2_WORD = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        err_align,
  output logic        err_range,
  output logic [7:0]  num1,
  output logic [7:0]  num2
);

  localparam int unsigned IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  // Byte count kept at 33 bits so a 2^30-word array still compares correctly.
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               err_align_q, err_align_d;
  logic               err_range_q, err_range_d;

  logic [31:0]        mem_q [RAM_WORDS];

  logic               range_err_c;
  logic               align_err_c;
  logic [IDX_W-1:0]   widx_c;
  logic [31:0]        rd_word_c;
  logic [7:0]         rd_byte_c;
  logic [15:0]        rd_half_c;
  logic [31:0]        load_c;
  logic [3:0]         st_be_c;
  logic [31:0]        st_lanes_c;

  logic               mem_we_c;
  logic [IDX_W-1:0]   mem_widx_c;
  logic [3:0]         mem_be_c;
  logic [31:0]        mem_wdata_c;

  // Access decode: error flags, lane extraction for loads, lane enables for stores.
  always_comb begin
    range_err_c = ({1'b0, addr} >= RAM_BYTES);
    align_err_c = 1'b0;
    if (!range_err_c) begin
      if (size == 2'b01) begin
        align_err_c = addr[0];
      end else if (size[1]) begin
        align_err_c = (addr[1:0] != 2'b00);
      end
    end

    widx_c    = addr[IDX_W+1:2];
    rd_word_c = mem_q[widx_c];
    rd_byte_c = rd_word_c[{addr[1:0], 3'b000} +: 8];
    rd_half_c = addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];

    case (size)
      2'b00:   load_c = {{24{sign_ext & rd_byte_c[7]}}, rd_byte_c};
      2'b01:   load_c = {{16{sign_ext & rd_half_c[15]}}, rd_half_c};
      default: load_c = rd_word_c;
    endcase

    // Replicate store data across lanes; the enables pick the live ones.
    case (size)
      2'b00: begin
        st_be_c    = 4'b0001 << addr[1:0];
        st_lanes_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be_c    = addr[1] ? 4'b1100 : 4'b0011;
        st_lanes_c = {2{wdata[15:0]}};
      end
      default: begin
        st_be_c    = 4'b1111;
        st_lanes_c = wdata;
      end
    endcase
  end

  // Next-state, array write port and registered response.
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_align_d = 1'b0;
    err_range_d = 1'b0;
    mem_we_c    = 1'b0;
    mem_widx_c  = clr_idx_q;
    mem_be_c    = 4'b1111;
    mem_wdata_c = 32'h0;

    case (state_q)
      ST_CLEAR: begin
        mem_we_c  = 1'b1;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(RAM_WORDS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rd || wr) begin
          err_range_d = range_err_c;
          err_align_d = align_err_c;
        end
        // Read uses current array contents, so rd+wr returns pre-write data.
        if (rd) begin
          rvalid_d = 1'b1;
          rdata_d  = (range_err_c || align_err_c) ? 32'h0 : load_c;
        end
        if (wr && !range_err_c && !align_err_c) begin
          mem_we_c    = 1'b1;
          mem_widx_c  = widx_c;
          mem_be_c    = st_be_c;
          mem_wdata_c = st_lanes_c;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    if (reset) begin
      mem_we_c = 1'b0;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      rdata_q     <= 32'h0;
      rvalid_q    <= 1'b0;
      err_align_q <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_align_q <= err_align_d;
      err_range_q <= err_range_d;
    end
  end

  // Storage array with per-lane write enables; cleared by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_c[b]) begin
          mem_q[mem_widx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
        end
      end
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign err_align = err_align_q;
  assign err_range = err_range_q;
  assign busy      = reset | (state_q == ST_CLEAR);
  assign num1      = mem_q[TAP1_WORD][7:0];
  assign num2      = mem_q[TAP2_WORD][7:0];

endmodule
